reg_writeback: RTL and testbench

Writer-side front end for the CPU register file. It merges single-cycle ALU results with multi-cycle load/multiply results into one registered write port (we3/wa3/wd3). Writes to R15 are steered to a separate PC-write port. It keeps a busy scoreboard of registers with outstanding long-latency writes, which hazard logic uses to stall issue. It sits between the execute/memory stages and the register file.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/wb_fifo.sv | 33 +++
 rtl/reg_writeback.sv | 76 +++++++
 tb/tb_reg_writeback.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared writeback entry type and register-file constants
package cpu_pkg;
  typedef struct packed {
    logic [3:0]  wa;
    logic [31:0] wd;
  } wb_entry_t;
  localparam logic [3:0] PC_IDX = 4'hF;
  localparam int NREGS = 16;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: power-of-two sync FIFO of writeback entries with registered count
module wb_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                din,
  output wb_entry_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and long-latency results into one registered
// register-file write port, steering R15 writes to the PC port.
module reg_writeback import cpu_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [3:0]       alu_wa,
  input  logic [31:0]      alu_wd,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [3:0]       ld_wa,
  input  logic [31:0]      ld_wd,
  input  logic             rsv_valid,
  input  logic [3:0]       rsv_wa,
  output logic [NREGS-1:0] busy,
  output logic             alu_stall,
  output logic             we3,
  output logic [3:0]       wa3,
  output logic [31:0]      wd3,
  output logic             pc_we,
  output logic [31:0]      pc_wd,
  output logic             ovr_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic push, pop, full, empty, sel_valid, starved, unused_count;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [SW-1:0] starve_cnt, starve_inc;
  logic [NREGS-1:0] busy_nxt;
  wb_entry_t head, sel;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din({ld_wa, ld_wd}), .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign unused_count = ^fifo_count;
  assign ld_ready = !full;
  assign push = ld_valid && ld_ready;
  assign pop = !alu_valid && !empty;
  assign sel_valid = alu_valid || pop;
  assign sel = alu_valid ? {alu_wa, alu_wd} : head;
  assign starve_inc = starve_cnt + SW'(1);
  assign starved = starve_inc == SW'(STARVE_MAX);
  // A new reservation overrides the clear from a same-cycle pop.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.wa] = 1'b0;
    if (rsv_valid) busy_nxt[rsv_wa] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy <= '0;
      alu_stall <= 1'b0;
      ovr_err <= 1'b0;
      starve_cnt <= '0;
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
    end else begin
      busy <= busy_nxt;
      ovr_err <= ovr_err || (alu_valid && alu_stall);
      // Without a pop while non-empty, alu_valid is necessarily high here.
      alu_stall <= !empty && !pop && starved;
      starve_cnt <= (empty || pop || starved) ? '0 : starve_inc;
      we3 <= sel_valid && sel.wa != PC_IDX;
      pc_we <= sel_valid && sel.wa == PC_IDX;
      if (sel_valid) begin
        wa3 <= sel.wa;
        wd3 <= sel.wd;
      end
      if (sel_valid && sel.wa == PC_IDX) pc_wd <= sel.wd;
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: table-driven directed vectors plus hand-written multi-cycle sequences
module tb_reg_writeback;
  logic clk = 1'b0, reset = 1'b1;
  logic alu_valid = 1'b0, ld_valid = 1'b0, rsv_valid = 1'b0;
  logic [3:0] alu_wa = '0, ld_wa = '0, rsv_wa = '0;
  logic [31:0] alu_wd = '0, ld_wd = '0;
  logic ld_ready, alu_stall, we3, pc_we, ovr_err;
  logic [15:0] busy;
  logic [3:0] wa3;
  logic [31:0] wd3, pc_wd;
  int total = 0, bad = 0;

  typedef struct {
    logic av; logic [3:0] aw; logic [31:0] ad;
    logic lv; logic [3:0] lw; logic [31:0] ld;
    logic rv; logic [3:0] rw;
    logic we; logic [3:0] wa; logic [31:0] wd;
    logic pwe; logic [31:0] pwd; logic [15:0] bsy; logic rdy;
  } vec_t;
  vec_t vt [12];

  reg_writeback #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .rsv_valid(rsv_valid), .rsv_wa(rsv_wa), .busy(busy), .alu_stall(alu_stall),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aw, input logic [31:0] ad,
                       input logic lv, input logic [3:0] lw, input logic [31:0] ld,
                       input logic rv, input logic [3:0] rw);
    alu_valid = av; alu_wa = aw; alu_wd = ad;
    ld_valid = lv; ld_wa = lw; ld_wd = ld;
    rsv_valid = rv; rsv_wa = rw;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          av aw    ad            lv lw    ld            rv rw    we wa    wd            pwe pwd           bsy       rdy
    vt[0]  = '{1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0,       0, 4'd0, 1, 4'd3, 32'hDEADBEEF, 0, 32'h0,      16'h0000, 1};
    vt[1]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       0, 4'd0, 0, 4'd3, 32'hDEADBEEF, 0, 32'h0,      16'h0000, 1};
    vt[2]  = '{1, 4'hF, 32'h100,      0, 4'd0, 32'h0,       0, 4'd0, 0, 4'hF, 32'h100,      1, 32'h100,    16'h0000, 1};
    vt[3]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       1, 4'd5, 0, 4'hF, 32'h100,      0, 32'h100,    16'h0020, 1};
    vt[4]  = '{0, 4'd0, 32'h0,        1, 4'd5, 32'h1234,    0, 4'd0, 0, 4'hF, 32'h100,      0, 32'h100,    16'h0020, 1};
    vt[5]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       0, 4'd0, 1, 4'd5, 32'h1234,     0, 32'h100,    16'h0000, 1};
    vt[6]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       1, 4'd7, 0, 4'd5, 32'h1234,     0, 32'h100,    16'h0080, 1};
    vt[7]  = '{1, 4'd2, 32'h22,       1, 4'd7, 32'h77,      0, 4'd0, 1, 4'd2, 32'h22,       0, 32'h100,    16'h0080, 1};
    vt[8]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       1, 4'd7, 1, 4'd7, 32'h77,       0, 32'h100,    16'h0080, 1};
    vt[9]  = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       0, 4'd0, 0, 4'd7, 32'h77,       0, 32'h100,    16'h0080, 1};
    vt[10] = '{0, 4'd0, 32'h0,        1, 4'hF, 32'hCAFE,    0, 4'd0, 0, 4'd7, 32'h77,       0, 32'h100,    16'h0080, 1};
    vt[11] = '{0, 4'd0, 32'h0,        0, 4'd0, 32'h0,       0, 4'd0, 0, 4'hF, 32'hCAFE,     1, 32'hCAFE,   16'h0080, 1};

    #12;
    chk("rst_we3", 32'(we3), 0); chk("rst_wa3", 32'(wa3), 0); chk("rst_wd3", wd3, 0);
    chk("rst_pc_we", 32'(pc_we), 0); chk("rst_pc_wd", pc_wd, 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_ld_ready", 32'(ld_ready), 1); chk("rst_stall", 32'(alu_stall), 0); chk("rst_ovr", 32'(ovr_err), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].av, vt[i].aw, vt[i].ad, vt[i].lv, vt[i].lw, vt[i].ld, vt[i].rv, vt[i].rw);
      tick();
      chk($sformatf("v%0d_we3", i), 32'(we3), 32'(vt[i].we));
      chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(vt[i].wa));
      chk($sformatf("v%0d_wd3", i), wd3, vt[i].wd);
      chk($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(vt[i].pwe));
      chk($sformatf("v%0d_pc_wd", i), pc_wd, vt[i].pwd);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].bsy));
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(vt[i].rdy));
      chk($sformatf("v%0d_stall", i), 32'(alu_stall), 0);
    end

    // Contention: ALU held busy, FIFO fills, starvation forces one drain slot
    drive(1, 4'd1, 32'h1, 1, 4'd8, 32'hA8, 0, 4'd0); tick();
    chk("ct_ready1", 32'(ld_ready), 1);
    drive(1, 4'd1, 32'h2, 1, 4'd9, 32'hA9, 0, 4'd0); tick();
    chk("ct_full", 32'(ld_ready), 0); chk("ct_alu_wins", wd3, 32'h2);
    drive(1, 4'd1, 32'h3, 1, 4'd10, 32'hA10, 0, 4'd0); tick();
    chk("ct_still_full", 32'(ld_ready), 0); chk("ct_nostall3", 32'(alu_stall), 0);
    tick();
    chk("ct_nostall4", 32'(alu_stall), 0);
    tick();
    chk("ct_stall", 32'(alu_stall), 1); chk("ct_wa3_alu", 32'(wa3), 1);
    alu_valid = 1'b0; tick();
    chk("ct_pop1_wa", 32'(wa3), 8); chk("ct_pop1_wd", wd3, 32'hA8); chk("ct_pop1_we", 32'(we3), 1);
    chk("ct_stall_off", 32'(alu_stall), 0); chk("ct_ready_back", 32'(ld_ready), 1);
    tick();
    chk("ct_pop2_wa", 32'(wa3), 9); chk("ct_pop2_wd", wd3, 32'hA9); chk("ct_ready2", 32'(ld_ready), 1);
    ld_valid = 1'b0; tick();
    chk("ct_pop3_wa", 32'(wa3), 10); chk("ct_pop3_wd", wd3, 32'hA10);
    tick();
    chk("ct_idle_we3", 32'(we3), 0); chk("ct_no_ovr", 32'(ovr_err), 0);

    // ALU ignoring a stall request: ALU still wins, ovr_err sticks
    drive(1, 4'd1, 32'h11, 1, 4'd12, 32'hC12, 0, 4'd0); tick();
    ld_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("ov_stall", 32'(alu_stall), 1); chk("ov_pre", 32'(ovr_err), 0);
    drive(1, 4'd2, 32'h66, 0, 4'd0, 32'h0, 0, 4'd0); tick();
    chk("ov_set", 32'(ovr_err), 1); chk("ov_alu_wa", 32'(wa3), 2); chk("ov_alu_wd", wd3, 32'h66);
    chk("ov_stall_off", 32'(alu_stall), 0);
    alu_valid = 1'b0; tick();
    chk("ov_pop_wa", 32'(wa3), 12); chk("ov_pop_wd", wd3, 32'hC12); chk("ov_sticky", 32'(ovr_err), 1);

    // Reset with two queued entries and busy=0x00A0
    drive(1, 4'd1, 32'h1, 1, 4'd5, 32'h55, 1, 4'd5); tick();
    drive(1, 4'd1, 32'h2, 1, 4'd7, 32'h77, 0, 4'd0); tick();
    chk("rm_busy", 32'(busy), 32'h00A0); chk("rm_full", 32'(ld_ready), 0);
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 0, 4'd0);
    #2 reset = 1'b1;
    #1;
    chk("rm_busy0", 32'(busy), 0); chk("rm_ready", 32'(ld_ready), 1); chk("rm_we3", 32'(we3), 0);
    chk("rm_ovr", 32'(ovr_err), 0); chk("rm_pc_wd", pc_wd, 0); chk("rm_wd3", wd3, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rm_stale_we%0d", i), {31'b0, we3 | pc_we}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
